// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Counter must hold BIN_W-1; one spare bit keeps BIN_W=1 legal.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return int'($clog2(bin_w)) + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bin2bcd_seq_ctrl_if #(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, output bin, input busy, input done, input bcd, input ovf);
  modport slave  (input start, input bin, output busy, output done, output bcd, output ovf);

endinterface

// File: rtl/bin2bcd_seq_ctrl_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the shift.
module bcd_add3_nibble
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] adj_c
);

  assign adj_c = (nib_i >= BCD_ADJ_THRESH) ? 4'(nib_i + BCD_ADJ_ADD) : nib_i;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Bit-serial binary-to-BCD converter: one shift-and-add-3 step per clock,
// start/busy/done handshake, result and overflow held until the next completion.
module bin2bcd_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  bin2bcd_seq_ctrl_if.slave  io
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = cnt_width(BIN_W);

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shreg_q, shreg_d;
  logic [SW-1:0]     scr_q, scr_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [SW-1:0]     adj_c;
  logic [SW-1:0]     scr_shift_c;
  logic [BIN_W-1:0]  shreg_shift_c;
  logic              carry_out_c;
  logic              last_c;

  // All nibbles corrected in parallel from the pre-shift scratch value.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_adj
    bcd_add3_nibble u_adj (
      .nib_i (scr_q[4*g +: 4]),
      .adj_c (adj_c[4*g +: 4])
    );
  end

  assign carry_out_c   = adj_c[SW-1];
  assign scr_shift_c   = {adj_c[SW-2:0], shreg_q[BIN_W-1]};
  assign shreg_shift_c = BIN_W'({shreg_q, 1'b0});
  assign last_c        = (cnt_q == CW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          shreg_d = io.bin;
          scr_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_shift_c;
        scr_d   = scr_shift_c;
        carry_d = carry_q | carry_out_c;
        cnt_d   = cnt_q + CW'(1);
        // Final shift publishes the result; carry from this shift still counts.
        if (last_c) begin
          bcd_d   = scr_shift_c;
          ovf_d   = carry_q | carry_out_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Bench for bin2bcd_seq_ctrl: default (9-bit) and 10-bit instances checked
// every cycle against a timing/arithmetic model, plus literal result checks.
module tb_bin2bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_ctrl_if #(.BIN_W(9),  .DIGITS(3)) io9  ();
  bin2bcd_seq_ctrl_if #(.BIN_W(10), .DIGITS(3)) io10 ();

  bin2bcd_seq_ctrl #(.BIN_W(9),  .DIGITS(3)) u_dut9  (.clk(clk), .rst_n(rst_n), .io(io9));
  bin2bcd_seq_ctrl #(.BIN_W(10), .DIGITS(3)) u_dut10 (.clk(clk), .rst_n(rst_n), .io(io10));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal digits of v modulo 1000, packed 4 bits per digit.
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    r = '0;
    x = v % 1000;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: accepted request completes BIN_W edges later with the decimal value.
  int          m_rem  [2];
  int          m_val  [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic [11:0] m_bcd  [2];
  logic        m_ovf  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rem[k] = 0; m_val[k] = 0; m_busy[k] = 1'b0;
        m_done[k] = 1'b0; m_bcd[k] = '0; m_ovf[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic s;
        int   b;
        s = (k == 0) ? io9.start : io10.start;
        b = (k == 0) ? int'(io9.bin) : int'(io10.bin);
        m_done[k] = 1'b0;
        if (m_busy[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
            m_bcd[k]  = to_bcd(m_val[k]);
            m_ovf[k]  = (m_val[k] >= 1000);
          end
        end else if (s) begin
          m_busy[k] = 1'b1;
          m_rem[k]  = (k == 0) ? 9 : 10;
          m_val[k]  = b;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy9",  16'(io9.busy),  16'(m_busy[0]));
      chk("done9",  16'(io9.done),  16'(m_done[0]));
      chk("bcd9",   16'(io9.bcd),   16'(m_bcd[0]));
      chk("ovf9",   16'(io9.ovf),   16'(m_ovf[0]));
      chk("busy10", 16'(io10.busy), 16'(m_busy[1]));
      chk("done10", 16'(io10.done), 16'(m_done[1]));
      chk("bcd10",  16'(io10.bcd),  16'(m_bcd[1]));
      chk("ovf10",  16'(io10.ovf),  16'(m_ovf[1]));
    end
  end

  // Issue one request and return at the negedge where done is seen.
  task automatic conv(input int k, input int val, output logic [11:0] got,
                      output logic gov, output int lat, output int busy_cnt);
    bit seen;
    if (k == 0) begin io9.start = 1'b1;  io9.bin  = 9'(val);  end
    else        begin io10.start = 1'b1; io10.bin = 10'(val); end
    lat = 0; busy_cnt = 0; got = '0; gov = 1'b0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      io9.start = 1'b0; io10.start = 1'b0;
      lat++;
      if (k == 0) begin
        if (io9.done) begin seen = 1'b1; got = io9.bcd; gov = io9.ovf; end
        else if (io9.busy) busy_cnt++;
      end else begin
        if (io10.done) begin seen = 1'b1; got = io10.bcd; gov = io10.ovf; end
        else if (io10.busy) busy_cnt++;
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done for value %0d on dut %0d", val, k);
    end
  endtask

  logic [11:0] got;
  logic        gov;
  int          lat, bcnt, ndone;

  initial begin
    int          v2 [3] = '{511, 255, 9};
    logic [11:0] e2 [3] = '{12'h511, 12'h255, 12'h009};
    int          v5 [3] = '{999, 1000, 1023};
    logic [11:0] e5 [3] = '{12'h999, 12'h000, 12'h023};
    logic        o5 [3] = '{1'b0, 1'b1, 1'b1};

    io9.start = 1'b0;  io9.bin  = '0;
    io10.start = 1'b0; io10.bin = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(io9.busy), 16'd0);
    chk("rst_done", 16'(io9.done), 16'd0);
    chk("rst_bcd",  16'(io9.bcd),  16'd0);
    chk("rst_ovf",  16'(io9.ovf),  16'd0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Zero: latency and busy width
    conv(0, 0, got, gov, lat, bcnt);
    chk("t1_lat",  16'(lat),  16'd10);
    chk("t1_busy", 16'(bcnt), 16'd9);
    chk("t1_bcd",  16'(got),  16'h000);
    chk("t1_ovf",  16'(gov),  16'd0);

    // Back-to-back requests launched in each done cycle
    for (int i = 0; i < 3; i++) begin
      conv(0, v2[i], got, gov, lat, bcnt);
      chk("t2_lat", 16'(lat), 16'd10);
      chk("t2_bcd", 16'(got), 16'(e2[i]));
      chk("t2_ovf", 16'(gov), 16'd0);
    end

    // Start and bin churn while busy must be ignored
    @(negedge clk);
    io9.start = 1'b1; io9.bin = 9'd100;
    ndone = 0; got = '0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      io9.start = (c >= 2 && c <= 5) ? c[0] : 1'b0;
      if (c >= 2 && c <= 5) io9.bin = 9'd7;
      if (io9.done) begin ndone++; got = io9.bcd; end
    end
    chk("t3_ndone", 16'(ndone), 16'd1);
    chk("t3_bcd",   16'(got),   16'h100);

    // Reset in the middle of a conversion aborts it
    conv(0, 5, got, gov, lat, bcnt);
    io9.start = 1'b1; io9.bin = 9'd300;
    @(negedge clk);
    io9.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (io9.done) ndone++;
    end
    chk("t4_ndone", 16'(ndone),    16'd0);
    chk("t4_bcd",   16'(io9.bcd),  16'h000);
    chk("t4_busy",  16'(io9.busy), 16'd0);
    conv(0, 42, got, gov, lat, bcnt);
    chk("t4_bcd42", 16'(got), 16'h042);

    // Ten-bit instance across the overflow boundary
    for (int i = 0; i < 3; i++) begin
      conv(1, v5[i], got, gov, lat, bcnt);
      chk("t5_lat", 16'(lat), 16'd11);
      chk("t5_bcd", 16'(got), 16'(e5[i]));
      chk("t5_ovf", 16'(gov), 16'(o5[i]));
    end

    // Full sweep of the 9-bit range with random idle gaps
    for (int v = 0; v < 512; v++) begin
      conv(0, v, got, gov, lat, bcnt);
      chk("t6_lat", 16'(lat), 16'd10);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Random start/bin traffic on the 10-bit instance
    for (int c = 0; c < 400; c++) begin
      io10.start = 1'($urandom_range(0, 1));
      io10.bin   = 10'($urandom);
      @(negedge clk);
    end
    io10.start = 1'b0;
    repeat (15) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Multi-cycle sequencer for binary-to-BCD conversion using the shift-and-add-3 (double dabble) algorithm. It processes one binary bit per clock, so a single narrow add-3 datapath is reused instead of an unrolled combinational chain. It takes one request at a time over a start/busy/done handshake. It sits between the binary value sources (counters, ALU results) and the BCD/7-segment display path, and holds the last result stable for the display.

Parameters:
BIN_W, 9, width of binary input in bits (>=1)
DIGITS, 3, number of BCD output digits (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse/level; sampled only when busy=0
bin  input  BIN_W  binary operand; captured on the accepting edge
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: bcd/ovf valid and newly updated
bcd  output  4*DIGITS  packed BCD result, digit 0 at [3:0]; held until next done
ovf  output  1  result exceeded 10^DIGITS-1; held with bcd

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE; busy=0, done=0, bcd=0, ovf=0; internal shift register, scratch and counter are cleared.
- FSM states are IDLE and SHIFT. The done pulse is a registered flag, not a state.
- IDLE with start=1 at edge E0: capture bin into the shift register, clear the scratch BCD register (4*DIGITS bits) and the sticky carry, set cnt=0, set busy=1, go to SHIFT.
- SHIFT, each edge:
  - Every scratch nibble >=5 gets +3 (all nibbles in parallel, computed from pre-shift values).
  - Then {carry_out, scratch, shreg} shifts left by 1, with the MSB of shreg entering scratch[0].
  - carry_out is ORed into the sticky ovf accumulator.
  - cnt increments.
- On the edge where cnt==BIN_W-1 (the BIN_W-th shift):
  - bcd <= corrected and shifted scratch.
  - ovf <= accumulated carry, including this shift.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at E0; done=1 and bcd valid in the cycle after edge E0+BIN_W. Throughput: one conversion per BIN_W+1 cycles.
- done is high for exactly one cycle and clears on the next edge unless another conversion completes on that edge.
- A start that arrives in the done cycle (state=IDLE) is accepted, giving back-to-back conversions with no dead cycle.
- start while busy=1 is ignored. bin changes during a conversion have no effect.
- bcd and ovf change only on the completing edge; they hold their values across IDLE and the next conversion.
- If ovf=1, bcd holds the low DIGITS digits of the result (modulo 10^DIGITS).
- Corrected nibbles stay <=12 before the shift, so no nibble overflows internally.
- cnt width is clog2(BIN_W)+1. For BIN_W=1 the first SHIFT edge is also the final edge.
- Reset asserted mid-conversion aborts immediately: all outputs go to reset values and no done is produced.

Decomposition:
- Shared package bcd_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT)
  - the constant BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3
  - the function cnt_width(BIN_W)
- One sub-module is natural: bcd_add3_nibble, a combinational 4-bit nibble corrector (out = in>=5 ? in+3 : in), instantiated DIGITS times by generate.

Test Plan:
1. Reset, then bin=9'd0, start pulse -> done 10 cycles after start edge (BIN_W=9), bcd=12'h000, ovf=0; busy high for 9 cycles prior.
2. bin=511, then 255, then 9, each started in the previous done cycle -> bcd=12'h511, 12'h255, 12'h009 on consecutive done pulses spaced 10 cycles apart, ovf=0.
3. Start bin=100, toggle start and change bin to 7 while busy -> single done, bcd=12'h100; the second request is ignored and done is never asserted twice.
4. Start bin=300, assert rst_n=0 at the 5th SHIFT cycle, release, wait 15 cycles -> no done pulse, bcd=0, busy=0; a new start with bin=42 gives bcd=12'h042.
5. Parameter override BIN_W=10, DIGITS=3: bin=999 -> bcd=12'h999, ovf=0; bin=1000 -> bcd=12'h000, ovf=1; bin=1023 -> bcd=12'h023, ovf=1.
6. Exhaustive sweep of bin 0..511 at default parameters -> every done matches a reference integer-to-BCD model; done width is always 1 cycle and bcd stays stable between dones.
